// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      START     = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   // Watchdog limit: twelve bit-times, which leaves margin over one 10-bit frame.
   function automatic int wd_limit(input int clk_rate, input int baud_rate);
      logic [63:0] cycles;
      if (baud_rate <= 0) begin
         cycles = 64'd1;
      end else begin
         cycles = (64'd12 * 64'(clk_rate)) / 64'(baud_rate);
      end
      return int'(cycles);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter.sv
// Two-requester packet arbiter feeding one UART transmitter, one byte at a time.
// A grant is held for a whole packet (until a LAST byte completes), and a
// watchdog recovers the arbiter if the transmitter never reports completion.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int CLK_RATE  = 100000000,
   parameter int BAUD_RATE = 115200,
   parameter int WD_CYCLES = wd_limit(CLK_RATE, BAUD_RATE)
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic       REQ0_VALID_I,
   input  logic [7:0] REQ0_DATA_I,
   input  logic       REQ0_LAST_I,
   output logic       REQ0_READY_O,
   input  logic       REQ1_VALID_I,
   input  logic [7:0] REQ1_DATA_I,
   input  logic       REQ1_LAST_I,
   output logic       REQ1_READY_O,
   output logic       TX_START_O,
   output logic [7:0] TX_DATA_O,
   input  logic       TX_DONE_I,
   output logic [1:0] GRANT_O,
   output logic       BUSY_O,
   output logic       ERR_O
);

   localparam int              WD_W    = $clog2(WD_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

   state_t          state_q,   state_d;
   logic [1:0]      grant_q,   grant_d;
   logic            ptr_q,     ptr_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            last_q,    last_d;
   logic [WD_W-1:0] wd_cnt_q,  wd_cnt_d;

   logic            sel_valid;
   logic [7:0]      sel_data;
   logic            sel_last;
   logic            wd_expire;

   // The counter starts at zero in the first WAIT_DONE cycle, so the limit is hit one below WD_CYCLES.
   assign wd_expire = (wd_cnt_q == WD_LAST);

   // Route the granted requester's byte stream to the load path.
   always_comb begin
      sel_valid = (grant_q[0] && REQ0_VALID_I) || (grant_q[1] && REQ1_VALID_I);
      sel_data  = grant_q[1] ? REQ1_DATA_I : REQ0_DATA_I;
      sel_last  = grant_q[1] ? REQ1_LAST_I : REQ0_LAST_I;
   end

   // State register and datapath flops, all cleared asynchronously.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q   <= IDLE;
         grant_q   <= 2'b00;
         ptr_q     <= 1'b0;
         tx_data_q <= 8'h00;
         last_q    <= 1'b0;
         wd_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         tx_data_q <= tx_data_d;
         last_q    <= last_d;
         wd_cnt_q  <= wd_cnt_d;
      end
   end

   // Next-state logic; on packet end the pointer aims at the requester that was not just served.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      tx_data_d = tx_data_q;
      last_d    = last_q;
      wd_cnt_d  = '0;
      case (state_q)
         IDLE: begin
            if (REQ0_VALID_I || REQ1_VALID_I) begin
               if (REQ0_VALID_I && REQ1_VALID_I) begin
                  grant_d = ptr_q ? 2'b10 : 2'b01;
               end else begin
                  grant_d = REQ1_VALID_I ? 2'b10 : 2'b01;
               end
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (sel_valid) begin
               tx_data_d = sel_data;
               last_d    = sel_last;
               state_d   = START;
            end
         end
         START: begin
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            wd_cnt_d = wd_cnt_q + 1'b1;
            if (TX_DONE_I) begin
               if (last_q) begin
                  state_d = IDLE;
                  grant_d = 2'b00;
                  ptr_d   = grant_q[0];
               end else begin
                  state_d = LOAD;
               end
            end else if (wd_expire) begin
               state_d = IDLE;
               grant_d = 2'b00;
               ptr_d   = grant_q[0];
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded from the current state; ERR_O yields to a same-cycle TX_DONE_I.
   always_comb begin
      REQ0_READY_O = (state_q == LOAD) && grant_q[0];
      REQ1_READY_O = (state_q == LOAD) && grant_q[1];
      TX_START_O   = (state_q == START);
      TX_DATA_O    = tx_data_q;
      GRANT_O      = grant_q;
      BUSY_O       = (state_q != IDLE);
      ERR_O        = (state_q == WAIT_DONE) && !TX_DONE_I && wd_expire;
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a packet-level round-robin model.
module tb_uart_tx_arbiter;

   localparam int WD = 16;

   logic       CLK_I;
   logic       RST_I;
   logic       REQ0_VALID_I;
   logic [7:0] REQ0_DATA_I;
   logic       REQ0_LAST_I;
   logic       REQ0_READY_O;
   logic       REQ1_VALID_I;
   logic [7:0] REQ1_DATA_I;
   logic       REQ1_LAST_I;
   logic       REQ1_READY_O;
   logic       TX_START_O;
   logic [7:0] TX_DATA_O;
   logic       TX_DONE_I;
   logic [1:0] GRANT_O;
   logic       BUSY_O;
   logic       ERR_O;

   int errors = 0;
   int checks = 0;

   // Pending bytes per requester as {last, data}; expected transmit order as {grant, data}.
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [9:0] exp_q[$];

   int         stall0, stall1, done_timer, fixed_delay, wd_count, next_pref;
   bit         stall_en, withhold_next, wd_active, wd_after, prev_start, hs0, hs1;
   logic [7:0] data_model;

   uart_tx_arbiter #(.WD_CYCLES(WD)) dut (
      .CLK_I        (CLK_I),
      .RST_I        (RST_I),
      .REQ0_VALID_I (REQ0_VALID_I),
      .REQ0_DATA_I  (REQ0_DATA_I),
      .REQ0_LAST_I  (REQ0_LAST_I),
      .REQ0_READY_O (REQ0_READY_O),
      .REQ1_VALID_I (REQ1_VALID_I),
      .REQ1_DATA_I  (REQ1_DATA_I),
      .REQ1_LAST_I  (REQ1_LAST_I),
      .REQ1_READY_O (REQ1_READY_O),
      .TX_START_O   (TX_START_O),
      .TX_DATA_O    (TX_DATA_O),
      .TX_DONE_I    (TX_DONE_I),
      .GRANT_O      (GRANT_O),
      .BUSY_O       (BUSY_O),
      .ERR_O        (ERR_O)
   );

   initial begin
      CLK_I = 1'b0;
      forever #5 CLK_I = ~CLK_I;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drive requester and transmitter inputs for the coming clock edge.
   task automatic applyStimulus();
      TX_DONE_I = 1'b0;
      if (done_timer > 0) begin
         done_timer--;
         if (done_timer == 0) TX_DONE_I = 1'b1;
      end
      REQ0_VALID_I = (q0.size() > 0) && (stall0 == 0);
      if (stall0 > 0) stall0--;
      if (REQ0_VALID_I) begin
         REQ0_DATA_I = q0[0][7:0];
         REQ0_LAST_I = q0[0][8];
      end else begin
         REQ0_DATA_I = 8'($urandom);
         REQ0_LAST_I = 1'($urandom);
      end
      REQ1_VALID_I = (q1.size() > 0) && (stall1 == 0);
      if (stall1 > 0) stall1--;
      if (REQ1_VALID_I) begin
         REQ1_DATA_I = q1[0][7:0];
         REQ1_LAST_I = q1[0][8];
      end else begin
         REQ1_DATA_I = 8'($urandom);
         REQ1_LAST_I = 1'($urandom);
      end
   endtask

   // Compare the settled outputs of this cycle against the model.
   task automatic checkCycle();
      logic       err_exp;
      logic [9:0] want;
      err_exp = 1'b0;
      if (wd_after) begin
         checkOutput("wd_idle_busy", 32'(BUSY_O), 32'd0);
         checkOutput("wd_idle_grant", 32'(GRANT_O), 32'd0);
         wd_after = 1'b0;
      end
      if (wd_active) begin
         wd_count++;
         if (wd_count == WD) begin
            err_exp   = 1'b1;
            wd_active = 1'b0;
            wd_after  = 1'b1;
         end
      end
      checkOutput("err_pulse", 32'(ERR_O), 32'(err_exp));
      if (TX_START_O) begin
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checkOutput("start_order", {22'd0, GRANT_O, TX_DATA_O}, {22'd0, want});
         end else begin
            checkOutput("start_unexpected", 32'(TX_START_O), 32'd0);
         end
         checkOutput("start_width", 32'(prev_start), 32'd0);
         if (withhold_next) begin
            withhold_next = 1'b0;
            wd_active     = 1'b1;
            wd_count      = 0;
         end else begin
            done_timer = ((fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 12))) + 1;
         end
      end
      checkOutput("ready0_ungranted", 32'(REQ0_READY_O && !GRANT_O[0]), 32'd0);
      checkOutput("ready1_ungranted", 32'(REQ1_READY_O && !GRANT_O[1]), 32'd0);
      checkOutput("tx_data_hold", 32'(TX_DATA_O), 32'(data_model));
      prev_start = TX_START_O;
      hs0 = REQ0_VALID_I && REQ0_READY_O;
      hs1 = REQ1_VALID_I && REQ1_READY_O;
   endtask

   task automatic stepCycle();
      logic [8:0] b;
      @(posedge CLK_I);
      #1;
      if (hs0) begin
         b = q0.pop_front();
         data_model = b[7:0];
         if (!b[8] && stall_en) stall0 = $urandom_range(0, 3);
      end
      if (hs1) begin
         b = q1.pop_front();
         data_model = b[7:0];
         if (!b[8] && stall_en) stall1 = $urandom_range(0, 3);
      end
      hs0 = 1'b0;
      hs1 = 1'b0;
      applyStimulus();
      #1;
      checkCycle();
   endtask

   task automatic runTraffic(input int budget);
      int n = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && done_timer == 0 &&
               !BUSY_O && !wd_active && !wd_after) && n < budget) begin
         stepCycle();
         n++;
      end
      checkOutput("drained", 32'(n < budget), 32'd1);
   endtask

   // Packet-level arbitration model: whole packets alternate while both sides wait.
   task automatic buildExpected(input int first, output int next_first);
      logic [8:0] c0[$];
      logic [8:0] c1[$];
      logic [8:0] b;
      int         pref;
      int         who;
      bit         ended;
      c0 = q0;
      c1 = q1;
      pref = first;
      while (c0.size() > 0 || c1.size() > 0) begin
         if (c0.size() > 0 && c1.size() > 0) who = pref;
         else who = (c0.size() > 0) ? 0 : 1;
         ended = 1'b0;
         while (!ended) begin
            if (who == 0) b = c0.pop_front();
            else b = c1.pop_front();
            exp_q.push_back({(who == 0) ? 2'b01 : 2'b10, b[7:0]});
            ended = b[8] || ((who == 0) ? (c0.size() == 0) : (c1.size() == 0));
         end
         pref = 1 - who;
      end
      next_first = pref;
   endtask

   task automatic genPackets(input int n);
      int len;
      for (int p = 0; p < n; p++) begin
         len = $urandom_range(1, 4);
         for (int i = 0; i < len; i++) q0.push_back({1'(i == len - 1), 8'($urandom)});
         len = $urandom_range(1, 4);
         for (int i = 0; i < len; i++) q1.push_back({1'(i == len - 1), 8'($urandom)});
      end
   endtask

   task automatic clearModel();
      q0.delete();
      q1.delete();
      exp_q.delete();
      stall0 = 0; stall1 = 0; done_timer = 0; wd_count = 0;
      wd_active = 1'b0; wd_after = 1'b0; withhold_next = 1'b0;
      prev_start = 1'b0; hs0 = 1'b0; hs1 = 1'b0;
      data_model = 8'h00;
      REQ0_VALID_I = 1'b0; REQ1_VALID_I = 1'b0; TX_DONE_I = 1'b0;
   endtask

   task automatic checkAllReset(input string tag);
      checkOutput({tag, "_start"}, 32'(TX_START_O), 32'd0);
      checkOutput({tag, "_data"}, 32'(TX_DATA_O), 32'd0);
      checkOutput({tag, "_grant"}, 32'(GRANT_O), 32'd0);
      checkOutput({tag, "_busy"}, 32'(BUSY_O), 32'd0);
      checkOutput({tag, "_err"}, 32'(ERR_O), 32'd0);
      checkOutput({tag, "_ready0"}, 32'(REQ0_READY_O), 32'd0);
      checkOutput({tag, "_ready1"}, 32'(REQ1_READY_O), 32'd0);
   endtask

   task automatic doReset();
      RST_I = 1'b1;
      clearModel();
      repeat (2) @(posedge CLK_I);
      #1;
      checkAllReset("reset");
      #1;
      RST_I = 1'b0;
   endtask

   initial begin
      RST_I = 1'b1;
      REQ0_DATA_I = 8'h00; REQ0_LAST_I = 1'b0;
      REQ1_DATA_I = 8'h00; REQ1_LAST_I = 1'b0;
      fixed_delay = -1;
      stall_en = 1'b0;
      clearModel();
      doReset();

      // Three-byte packet from requester 0, with the IDLE->LOAD->START latency.
      q0 = '{9'h011, 9'h022, 9'h133};
      buildExpected(0, next_pref);
      stepCycle();
      checkOutput("lat_idle_ready0", 32'(REQ0_READY_O), 32'd0);
      stepCycle();
      checkOutput("lat_load_ready0", 32'(REQ0_READY_O), 32'd1);
      checkOutput("lat_load_grant", 32'(GRANT_O), 32'd1);
      checkOutput("lat_load_busy", 32'(BUSY_O), 32'd1);
      checkOutput("lat_load_start", 32'(TX_START_O), 32'd0);
      stepCycle();
      checkOutput("lat_start", 32'(TX_START_O), 32'd1);
      runTraffic(300);
      checkOutput("pkt3_grant_end", 32'(GRANT_O), 32'd0);

      // Done pulses while idle must not wake the arbiter.
      done_timer = 1;
      repeat (3) stepCycle();
      checkOutput("idle_done_busy", 32'(BUSY_O), 32'd0);

      // Both requesters contending, twice each: strict alternation from requester 0.
      doReset();
      q0 = '{9'h1A5, 9'h1A5};
      q1 = '{9'h15A, 9'h15A};
      buildExpected(0, next_pref);
      runTraffic(300);

      // Requester 1 waits behind a stalling multi-byte packet of requester 0.
      doReset();
      stall_en = 1'b1;
      q0 = '{9'h010, 9'h020, 9'h130};
      q1 = '{9'h140};
      buildExpected(0, next_pref);
      runTraffic(300);
      stall_en = 1'b0;

      // Watchdog timeout; the rest of the packet re-arbitrates behind requester 1.
      doReset();
      q0 = '{9'h077, 9'h188};
      q1 = '{9'h199};
      exp_q = '{10'h177, 10'h299, 10'h188};
      withhold_next = 1'b1;
      runTraffic(300);

      // Completion landing on the watchdog limit cycle wins over the timeout.
      doReset();
      fixed_delay = WD - 1;
      q0 = '{9'h1E1};
      buildExpected(0, next_pref);
      runTraffic(300);
      fixed_delay = -1;

      // Randomized traffic; the second round continues from the model's pointer.
      doReset();
      stall_en = 1'b1;
      next_pref = 0;
      for (int r = 0; r < 2; r++) begin
         genPackets(5);
         buildExpected(next_pref, next_pref);
         runTraffic(4000);
      end
      stall_en = 1'b0;

      // Reset while waiting for completion abandons the packet silently.
      doReset();
      fixed_delay = 12;
      q0 = '{9'h0B1, 9'h1B2};
      buildExpected(0, next_pref);
      for (int i = 0; i < 10 && !prev_start; i++) stepCycle();
      checkOutput("mid_start_seen", 32'(prev_start), 32'd1);
      repeat (4) stepCycle();
      checkOutput("mid_busy_before", 32'(BUSY_O), 32'd1);
      RST_I = 1'b1;
      #1;
      checkAllReset("mid_rst");
      doReset();
      fixed_delay = -1;
      repeat (12) stepCycle();
      checkOutput("mid_after_busy", 32'(BUSY_O), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
